// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: button conditioning, run/pause/set/done FSM,
// 10 ms tick divider and done-state flash generator.
module stopwatch_ctrl #(
    parameter int DEB_CYCLES = 1_000_000,
    parameter int TICK_DIV   = 1_000_000,
    parameter int FLASH_DIV  = 25_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       lap,
    input  logic       clr,
    input  logic       TimeSet,
    input  logic       dir,
    input  logic       at_zero,
    output logic       count_en,
    output logic       count_clr,
    output logic       count_dir,
    output logic       lap_load,
    output logic       lap_view,
    output logic       flash,
    output logic       set_mode,
    output logic       set_inc,
    output logic [1:0] set_digit,
    output logic [2:0] state
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] RUN   = 3'd1;
    localparam logic [2:0] PAUSE = 3'd2;
    localparam logic [2:0] SET   = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    localparam int unsigned NBTN = 5;
    localparam int unsigned DW   = $clog2(DEB_CYCLES + 1);
    localparam int unsigned TW   = $clog2(TICK_DIV + 1);
    localparam int unsigned FW   = $clog2(FLASH_DIV + 1);

    localparam logic [DW-1:0] DEB_LAST   = DW'(DEB_CYCLES - 1);
    localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
    localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_DIV - 1);

    // bit order: 0 clr, 1 stop, 2 start, 3 lap, 4 TimeSet
    logic [NBTN-1:0] btn_raw;
    logic [NBTN-1:0] sync1;
    logic [NBTN-1:0] sync2;
    logic [NBTN-1:0] deb;
    logic [NBTN-1:0] deb_valid;
    logic [NBTN-1:0] press;
    logic [DW-1:0]   deb_cnt [NBTN];

    logic p_clr, p_stop, p_start, p_lap, p_set;

    logic [TW-1:0] tick_cnt;
    logic [FW-1:0] flash_cnt;

    assign btn_raw  = {TimeSet, lap, start, stop, clr};
    assign set_mode = (state == SET);

    // Synchronize and debounce every button; emit a press pulse on an accepted rising level.
    // After reset each debouncer first learns the current stable level without emitting a
    // press, so a button held through reset must be released and pressed again.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1     <= '0;
            sync2     <= '0;
            deb       <= '0;
            deb_valid <= '0;
            press     <= '0;
            for (int unsigned i = 0; i < NBTN; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
            for (int unsigned i = 0; i < NBTN; i++) begin
                press[i] <= 1'b0;
                if (!deb_valid[i]) begin
                    if (sync2[i] != deb[i]) begin
                        deb[i]     <= sync2[i];
                        deb_cnt[i] <= DW'(1);
                    end else if (deb_cnt[i] == DEB_LAST) begin
                        deb_valid[i] <= 1'b1;
                        deb_cnt[i]   <= '0;
                    end else begin
                        deb_cnt[i] <= deb_cnt[i] + 1'b1;
                    end
                end else if (sync2[i] != deb[i]) begin
                    if (deb_cnt[i] == DEB_LAST) begin
                        deb[i]     <= sync2[i];
                        deb_cnt[i] <= '0;
                        press[i]   <= sync2[i];
                    end else begin
                        deb_cnt[i] <= deb_cnt[i] + 1'b1;
                    end
                end else begin
                    deb_cnt[i] <= '0;
                end
            end
        end
    end

    // Keep only the highest-priority press of the cycle: clr > stop > start > lap > TimeSet.
    always_comb begin
        p_clr   = press[0];
        p_stop  = press[1] & ~press[0];
        p_start = press[2] & ~(|press[1:0]);
        p_lap   = press[3] & ~(|press[2:0]);
        p_set   = press[4] & ~(|press[3:0]);
    end

    // Main FSM with registered pulse outputs, tick divider and flash generator.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            count_en  <= 1'b0;
            count_clr <= 1'b0;
            count_dir <= 1'b0;
            lap_load  <= 1'b0;
            lap_view  <= 1'b0;
            flash     <= 1'b0;
            set_inc   <= 1'b0;
            set_digit <= '0;
            tick_cnt  <= '0;
            flash_cnt <= '0;
        end else begin
            count_en  <= 1'b0;
            count_clr <= 1'b0;
            lap_load  <= 1'b0;
            set_inc   <= 1'b0;
            case (state)
                IDLE: begin
                    if (p_clr) begin
                        count_clr <= 1'b1;
                    end else if (p_start) begin
                        state     <= RUN;
                        count_dir <= dir;
                        tick_cnt  <= '0;
                    end else if (p_set) begin
                        state     <= SET;
                        set_digit <= '0;
                    end
                end
                RUN: begin
                    if (count_dir && at_zero) begin
                        state     <= DONE;
                        flash     <= 1'b1;
                        flash_cnt <= '0;
                    end else begin
                        if (tick_cnt == TICK_LAST) begin
                            tick_cnt <= '0;
                            count_en <= 1'b1;
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                        if (p_stop) begin
                            state <= PAUSE;
                        end else if (p_lap) begin
                            lap_load <= 1'b1;
                            lap_view <= 1'b1;
                        end
                    end
                end
                PAUSE: begin
                    if (p_clr) begin
                        state     <= IDLE;
                        count_clr <= 1'b1;
                        lap_view  <= 1'b0;
                    end else if (p_start) begin
                        state <= RUN;
                    end else if (p_lap) begin
                        lap_view <= 1'b0;
                    end
                end
                SET: begin
                    if (p_clr) begin
                        count_clr <= 1'b1;
                    end else if (p_start) begin
                        set_inc <= 1'b1;
                    end else if (p_lap) begin
                        set_digit <= set_digit + 1'b1;
                    end else if (p_set) begin
                        state <= IDLE;
                    end
                end
                DONE: begin
                    if (p_clr) begin
                        state     <= IDLE;
                        count_clr <= 1'b1;
                        flash     <= 1'b0;
                        flash_cnt <= '0;
                    end else if (flash_cnt == FLASH_LAST) begin
                        flash_cnt <= '0;
                        flash     <= ~flash;
                    end else begin
                        flash_cnt <= flash_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    flash <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: directed scenarios plus random
// button traffic, every cycle compared against a behavioural model.
module tb_stopwatch_ctrl;

    localparam int DEB  = 4;
    localparam int TDIV = 10;
    localparam int FDIV = 8;

    localparam int CLR   = 0;
    localparam int STOP  = 1;
    localparam int START = 2;
    localparam int LAP   = 3;
    localparam int TSET  = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] btn = '0;
    logic       dir = 1'b0;
    logic       at_zero = 1'b0;

    logic       count_en, count_clr, count_dir, lap_load, lap_view;
    logic       flash, set_mode, set_inc;
    logic [1:0] set_digit;
    logic [2:0] state;

    stopwatch_ctrl #(
        .DEB_CYCLES(DEB),
        .TICK_DIV  (TDIV),
        .FLASH_DIV (FDIV)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (btn[START]),
        .stop     (btn[STOP]),
        .lap      (btn[LAP]),
        .clr      (btn[CLR]),
        .TimeSet  (btn[TSET]),
        .dir      (dir),
        .at_zero  (at_zero),
        .count_en (count_en),
        .count_clr(count_clr),
        .count_dir(count_dir),
        .lap_load (lap_load),
        .lap_view (lap_view),
        .flash    (flash),
        .set_mode (set_mode),
        .set_inc  (set_inc),
        .set_digit(set_digit),
        .state    (state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // ---------------- behavioural model ----------------
    int m_state, m_digit, m_tick, m_fcnt;
    bit m_en, m_cclr, m_dir, m_lapl, m_lapv, m_flash, m_inc;
    bit dly0 [5];
    bit dly1 [5];
    bit prev_s [5];
    bit acc [5];
    bit ok [5];
    bit pr [5];
    int run_len [5];
    int mdl_en_cnt;

    function automatic void model_reset();
        m_state = 0; m_digit = 0; m_tick = 0; m_fcnt = 0;
        m_en = 0; m_cclr = 0; m_dir = 0; m_lapl = 0; m_lapv = 0; m_flash = 0; m_inc = 0;
        for (int i = 0; i < 5; i++) begin
            dly0[i] = 0; dly1[i] = 0; prev_s[i] = 0; acc[i] = 0; ok[i] = 0; pr[i] = 0; run_len[i] = 0;
        end
    endfunction

    function automatic void model_edge();
        int hp;
        bit samp;
        hp = -1;
        for (int i = 0; i < 5; i++) if (pr[i] && hp < 0) hp = i;
        m_en = 0; m_cclr = 0; m_lapl = 0; m_inc = 0;
        case (m_state)
            0: begin
                if (hp == CLR) m_cclr = 1;
                else if (hp == START) begin m_state = 1; m_dir = dir; m_tick = 0; end
                else if (hp == TSET) begin m_state = 3; m_digit = 0; end
            end
            1: begin
                if (m_dir && at_zero) begin
                    m_state = 4; m_flash = 1; m_fcnt = 0;
                end else begin
                    m_tick = (m_tick + 1) % TDIV;
                    m_en = (m_tick == 0);
                    if (hp == STOP) m_state = 2;
                    else if (hp == LAP) begin m_lapl = 1; m_lapv = 1; end
                end
            end
            2: begin
                if (hp == CLR) begin m_state = 0; m_cclr = 1; m_lapv = 0; end
                else if (hp == START) m_state = 1;
                else if (hp == LAP) m_lapv = 0;
            end
            3: begin
                if (hp == CLR) m_cclr = 1;
                else if (hp == START) m_inc = 1;
                else if (hp == LAP) m_digit = (m_digit + 1) % 4;
                else if (hp == TSET) m_state = 0;
            end
            default: begin
                if (hp == CLR) begin m_state = 0; m_cclr = 1; m_flash = 0; end
                else begin
                    m_fcnt = m_fcnt + 1;
                    if (m_fcnt == FDIV) begin m_fcnt = 0; m_flash = !m_flash; end
                end
            end
        endcase
        if (m_en) mdl_en_cnt++;
        // button conditioning: level accepted after DEB equal synchronized samples
        for (int i = 0; i < 5; i++) begin
            samp = dly1[i];
            run_len[i] = (samp == prev_s[i]) ? run_len[i] + 1 : 1;
            prev_s[i] = samp;
            pr[i] = 0;
            if (!ok[i]) begin
                if (run_len[i] >= DEB) begin ok[i] = 1; acc[i] = samp; end
            end else if (samp != acc[i] && run_len[i] >= DEB) begin
                acc[i] = samp;
                pr[i] = samp;
            end
            dly1[i] = dly0[i];
            dly0[i] = btn[i];
        end
    endfunction

    function automatic logic [12:0] exp_vec();
        return {3'(m_state), m_en, m_cclr, m_dir, m_lapl, m_lapv, m_flash,
                (m_state == 3), m_inc, 2'(m_digit)};
    endfunction

    // ---------------- observation ----------------
    int en_cnt, lapl_cnt, cclr_cnt, inc_cnt, run_entries, run_since;
    logic [2:0] prev_state = '0;
    int gaps [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk($sformatf("cycle%0d", cyc),
            32'({state, count_en, count_clr, count_dir, lap_load, lap_view, flash,
                 set_mode, set_inc, set_digit}),
            32'(exp_vec()));
    endtask

    task automatic monitor();
        if (count_en === 1'b1) begin
            en_cnt++;
            gaps.push_back(run_since);
            run_since = 0;
        end
        if (state === 3'd1) run_since++;
        else if (state !== 3'd2) run_since = 0;
        if (lap_load === 1'b1) lapl_cnt++;
        if (count_clr === 1'b1) cclr_cnt++;
        if (set_inc === 1'b1) inc_cnt++;
        if (prev_state === 3'd0 && state === 3'd1) run_entries++;
        prev_state = state;
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        if (rst) model_reset();
        else model_edge();
        #1;
        check_all();
        monitor();
    endtask

    task automatic press(input int b, input int hold);
        btn[b] = 1'b1;
        repeat (hold) step();
        btn[b] = 1'b0;
        repeat (DEB + 4) step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int k;
        int hold;
        logic [4:0] mask;

        // reset state
        model_reset();
        #1;
        check_all();
        chk("reset_outputs", 32'({count_en, count_clr, count_dir, lap_load, lap_view, flash,
                                  set_mode, set_inc, set_digit, state}), 32'd0);
        repeat (3) step();
        rst = 1'b0;
        repeat (8) step();

        // start held 100 cycles: one RUN entry, periodic count_en
        gaps.delete(); en_cnt = 0; mdl_en_cnt = 0; run_entries = 0; run_since = 0;
        btn[START] = 1'b1;
        repeat (100) step();
        btn[START] = 1'b0;
        repeat (DEB + 4) step();
        chk("run_after_hold", 32'(state), 32'd1);
        chk("single_run_entry", 32'(run_entries), 32'd1);
        chk("en_pulses", 32'(en_cnt), 32'(mdl_en_cnt));

        // pause and resume keep the partial tick
        press(STOP, 6);
        chk("paused", 32'(state), 32'd2);
        repeat (5) step();
        press(START, 6);
        chk("resumed", 32'(state), 32'd1);
        repeat (40) step();
        chk("gap_seen", 32'(gaps.size() >= 12), 32'd1);
        foreach (gaps[i]) chk($sformatf("tick_gap%0d", i), 32'(gaps[i]), 32'(TDIV));

        // laps in RUN, lap view cleared in PAUSE, clr back to IDLE
        lapl_cnt = 0; cclr_cnt = 0;
        press(LAP, 6);
        press(LAP, 7);
        chk("lap_loads", 32'(lapl_cnt), 32'd2);
        chk("lap_view_on", 32'(lap_view), 32'd1);
        press(STOP, 6);
        press(LAP, 6);
        chk("lap_view_off", 32'(lap_view), 32'd0);
        press(CLR, 6);
        chk("clr_pulses", 32'(cclr_cnt), 32'd1);
        chk("idle_after_clr", 32'(state), 32'd0);

        // count down reaching zero: DONE with flash 1,0,1
        dir = 1'b1; at_zero = 1'b1; en_cnt = 0;
        btn[START] = 1'b1;
        k = 0;
        while (state !== 3'd4 && k < 40) begin step(); k++; end
        chk("done_entry", 32'(state), 32'd4);
        btn[START] = 1'b0;
        chk("flash0", 32'(flash), 32'd1);
        repeat (FDIV) step();
        chk("flash1", 32'(flash), 32'd0);
        repeat (FDIV) step();
        chk("flash2", 32'(flash), 32'd1);
        chk("no_en_done", 32'(en_cnt), 32'd0);
        press(START, 6);
        chk("start_ignored_done", 32'(state), 32'd4);
        press(CLR, 6);
        chk("idle_from_done", 32'(state), 32'd0);
        chk("flash_off", 32'(flash), 32'd0);
        dir = 1'b0; at_zero = 1'b0;

        // set mode: 5 laps wrap digit to 1, start gives one increment
        press(TSET, 6);
        chk("set_state", 32'(state), 32'd3);
        chk("set_mode_on", 32'(set_mode), 32'd1);
        repeat (5) press(LAP, 6);
        inc_cnt = 0;
        press(START, 6);
        chk("set_digit_wrap", 32'(set_digit), 32'd1);
        chk("set_inc_once", 32'(inc_cnt), 32'd1);
        press(TSET, 6);
        chk("set_exit", 32'(state), 32'd0);

        // clr beats stop in the same cycle while paused
        press(START, 6);
        press(STOP, 6);
        chk("pause_again", 32'(state), 32'd2);
        cclr_cnt = 0;
        btn[CLR] = 1'b1; btn[STOP] = 1'b1;
        repeat (6) step();
        btn[CLR] = 1'b0; btn[STOP] = 1'b0;
        repeat (DEB + 4) step();
        chk("clr_wins", 32'(state), 32'd0);
        chk("clr_wins_pulse", 32'(cclr_cnt), 32'd1);

        // reset mid-RUN with start held
        press(START, 6);
        chk("run_before_rst", 32'(state), 32'd1);
        btn[START] = 1'b1;
        repeat (3) step();
        #3;
        rst = 1'b1;
        model_reset();
        #1;
        chk("async_reset", 32'({count_en, count_clr, count_dir, lap_load, lap_view, flash,
                                set_mode, set_inc, set_digit, state}), 32'd0);
        repeat (3) step();
        rst = 1'b0;
        repeat (30) step();
        chk("held_through_reset", 32'(state), 32'd0);
        btn[START] = 1'b0;
        repeat (DEB + 4) step();
        press(START, 6);
        chk("run_after_repress", 32'(state), 32'd1);

        // random traffic against the model
        for (int n = 0; n < 120; n++) begin
            mask = '0;
            mask[$urandom_range(0, 4)] = 1'b1;
            if ($urandom_range(0, 3) == 0) mask[$urandom_range(0, 4)] = 1'b1;
            dir     = 1'($urandom_range(0, 1));
            at_zero = ($urandom_range(0, 7) == 0);
            hold    = $urandom_range(1, 10);
            btn = mask;
            repeat (hold) step();
            btn = '0;
            repeat ($urandom_range(1, 12)) step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 1_000_000, meaning the number of cycles a synchronized button level must stay stable before it is accepted.
REQ-002 SHALL have parameter TICK_DIV, default 1_000_000, meaning the clk cycles per count_en pulse (10 ms at 100 MHz).
REQ-003 SHALL have parameter FLASH_DIV, default 25_000_000, meaning the clk cycles per flash toggle.
REQ-004 SHALL have one clock and an asynchronous active-high reset, with ports as follows:
- clk  in  1  system clock; all state on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- start, stop, lap, clr, TimeSet  in  1 each  raw, asynchronous push buttons, active-high.
- dir  in  1  count direction switch: 0 = up, 1 = down.
- at_zero  in  1  datapath reports that all digits are 0.
- count_en  out  1  one-cycle pulse that advances the time counters.
- count_clr  out  1  one-cycle pulse that clears the time counters.
- count_dir  out  1  latched direction.
- lap_load  out  1  one-cycle pulse that captures the lap registers.
- lap_view  out  1  display shows lap registers.
- flash  out  1  display blink enable.
- set_mode  out  1  time-set active.
- set_inc  out  1  one-cycle pulse that increments the selected digit.
- set_digit  out  2  digit selected in set mode: 0 = min, 1 = sec msd, 2 = sec lsd, 3 = ms.
- state  out  3  FSM state, for debug.

Function
REQ-005 SHALL pass each button through a 2-FF synchronizer, then a debouncer that accepts a new level after DEB_CYCLES consecutive equal samples.
REQ-006 SHALL produce a one-cycle press pulse on each debounced 0->1 edge. Release produces no pulse.
REQ-007 SHALL use FSM states IDLE=0, RUN=1, PAUSE=2, SET=3, DONE=4. Encodings 5-7 SHALL go to IDLE on the next cycle.
REQ-008 SHALL honour only the highest-priority press in a cycle: clr > stop > start > lap > TimeSet. Lower presses in the same cycle are discarded.
REQ-009 In IDLE: start -> RUN and count_dir<=dir; TimeSet -> SET with set_digit<=0; clr -> count_clr pulse, stay IDLE.
REQ-010 In RUN:
- stop -> PAUSE.
- lap -> lap_load pulse and lap_view<=1.
- clr is ignored.
- count_dir==1 && at_zero -> DONE, with no count_en issued in that cycle.
REQ-011 In PAUSE:
- start -> RUN.
- clr -> IDLE with count_clr pulse and lap_view<=0.
- lap -> lap_view<=0.
REQ-012 In SET:
- start -> set_inc pulse.
- lap -> set_digit<=set_digit+1, wrapping 3->0.
- TimeSet -> IDLE.
- clr -> count_clr pulse, stay SET.
- set_mode=1 only in this state.
REQ-013 In DONE: clr -> IDLE with count_clr pulse. All other presses are ignored.
REQ-014 The tick divider SHALL count 0..TICK_DIV-1 only in RUN and emit count_en when the count is TICK_DIV-1. It is zeroed on IDLE->RUN and held in PAUSE, so resuming loses no partial tick.
REQ-015 count_dir SHALL change only on the IDLE->RUN transition; dir changes at other times have no effect.
REQ-016 flash SHALL toggle every FLASH_DIV cycles while in DONE, starting at 1 on DONE entry, and SHALL be 0 in all other states.
REQ-017 All pulse outputs SHALL be registered, one cycle wide, and appear the cycle after the press pulse.

Reset
REQ-018 On rst=1, asynchronously set: state=IDLE; every output 0; set_digit=0; divider, flash counter, debouncers and synchronizers 0.
REQ-019 Reset asserted mid-RUN SHALL abort at once. After release, no press is generated for a button held through reset until it is released and pressed again.

Verification (DEB_CYCLES=4, TICK_DIV=10, FLASH_DIV=8)
REQ-020 Press start in IDLE and hold 100 cycles -> RUN; count_en pulses every 10 cycles; exactly one start pulse is generated.
REQ-021 RUN, then stop 3 cycles after a count_en, then start -> the next count_en comes 7 cycles after RUN re-entry.
REQ-022 RUN with lap pressed twice -> two lap_load pulses; lap_view=1. Then stop, lap -> lap_view=0. Then clr -> count_clr, IDLE.
REQ-023 dir=1, start, at_zero=1 -> DONE with no count_en; flash toggles 1,0,1 at 8-cycle spacing; start ignored; clr -> IDLE, flash=0.
REQ-024 TimeSet, then lap x5, then start -> set_digit=1 and one set_inc pulse. clr and stop pressed in the same cycle in PAUSE -> clr wins.
REQ-025 Reset mid-RUN with start held -> all outputs 0 immediately; no RUN entry until start is released and pressed again.
